// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Byte-addressed data-memory target for the multicycle CPU.
//               Accepts one load/store at a time over a valid/ready request
//               channel, waits WAIT cycles, then returns a one-cycle response
//               pulse. Stores are merged into little-endian byte lanes.
//
// Ports       : clk, reset             - clock, synchronous active-high reset
//               req_valid / req_ready  - request handshake
//               req_wr                 - 1 = store, 0 = load
//               req_size               - 00 word, 01 half, 10 byte, 11 reserved
//               req_addr               - byte address
//               req_wdata              - right-justified store data
//               rsp_valid              - one-cycle response pulse
//               rsp_rdata              - aligned word for loads, 0 otherwise
//               rsp_err                - request rejected (with rsp_valid)
//
// Config      : MEM_RESPONDER_ALIGN_CHK_EN
//               defined   -> misaligned, reserved-size and out-of-range
//                            requests are rejected with rsp_err
//               undefined -> rsp_err tied 0; addresses force-aligned, size 11
//                            treated as word, addresses wrap modulo capacity
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int ADDR_W = 8,
    parameter int WAIT   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         c_WORDS   = 2 ** (ADDR_W - 2);
    localparam logic [3:0] c_WAIT    = 4'(WAIT);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_WAITST  = 2'd1;
    localparam logic [1:0] c_RESP    = 2'd2;

    localparam logic [1:0] c_SZ_WORD = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_BYTE = 2'b10;
    localparam logic [1:0] c_SZ_RSVD = 2'b11;

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_err;
    logic [31:0]       r_rdata;
    logic              r_rsp_err;
    logic [31:0]       r_mem [0:c_WORDS-1];

    logic              w_accept;
    logic              w_err;
    logic [1:0]        w_size;
    logic [ADDR_W-1:0] w_addr;
    logic              w_enter_resp;
    logic [ADDR_W-3:0] w_rd_idx;
    logic              w_rd_wr;
    logic              w_rd_err;
    logic [3:0]        w_be;
    logic [31:0]       w_wlanes;

    assign w_accept  = (r_state == c_IDLE) && req_valid;
    assign req_ready = (r_state == c_IDLE);
    assign rsp_valid = (r_state == c_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_rsp_err;

    // Request qualification: either reject bad requests or normalise them.
`ifdef MEM_RESPONDER_ALIGN_CHK_EN
    always_comb begin
        w_err  = 1'b0;
        w_size = req_size;
        w_addr = req_addr[ADDR_W-1:0];
        if (req_size == c_SZ_RSVD)                          w_err = 1'b1;
        if ((req_size == c_SZ_HALF) && req_addr[0])         w_err = 1'b1;
        if ((req_size == c_SZ_WORD) && (req_addr[1:0] != 2'b00)) w_err = 1'b1;
        if (req_addr[31:ADDR_W] != '0)                      w_err = 1'b1;
    end
`else
    // High address bits are dropped so accesses wrap around the array.
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^req_addr[31:ADDR_W];

    always_comb begin
        w_err  = 1'b0;
        w_size = (req_size == c_SZ_RSVD) ? c_SZ_WORD : req_size;
        w_addr = req_addr[ADDR_W-1:0];
        if (w_size == c_SZ_HALF) w_addr[0]   = 1'b0;
        if (w_size == c_SZ_WORD) w_addr[1:0] = 2'b00;
    end
`endif

    // RESP is entered straight from IDLE when WAIT=0, before the request
    // registers hold the new request, so the read side takes the live,
    // qualified request in that case.
    assign w_enter_resp = (w_accept && (c_WAIT == 4'd0)) ||
                          ((r_state == c_WAITST) && (r_cnt == 4'd1));
    assign w_rd_idx     = (r_state == c_IDLE) ? w_addr[ADDR_W-1:2] : r_addr[ADDR_W-1:2];
    assign w_rd_wr      = (r_state == c_IDLE) ? req_wr : r_wr;
    assign w_rd_err     = (r_state == c_IDLE) ? w_err  : r_err;

    // Store lane steering: replicate the right-justified data across the
    // word and let the byte enables pick the lanes that change.
    always_comb begin
        w_be     = 4'b1111;
        w_wlanes = r_wdata;
        case (r_size)
            c_SZ_BYTE: begin
                w_be     = 4'b0001 << r_addr[1:0];
                w_wlanes = {4{r_wdata[7:0]}};
            end
            c_SZ_HALF: begin
                w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be     = 4'b1111;
                w_wlanes = r_wdata;
            end
        endcase
    end

    // Control FSM and request latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_cnt     <= 4'd0;
            r_wr      <= 1'b0;
            r_size    <= 2'b00;
            r_addr    <= '0;
            r_wdata   <= 32'd0;
            r_err     <= 1'b0;
            r_rdata   <= 32'd0;
            r_rsp_err <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_wr    <= req_wr;
                        r_size  <= w_size;
                        r_addr  <= w_addr;
                        r_wdata <= req_wdata;
                        r_err   <= w_err;
                        r_cnt   <= c_WAIT;
                        r_state <= (c_WAIT == 4'd0) ? c_RESP : c_WAITST;
                    end
                end
                c_WAITST: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= c_RESP;
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase

            // Response registers are loaded on the edge into RESP and
            // cleared on the edge out of it.
            if (w_enter_resp) begin
                r_rdata   <= (w_rd_wr || w_rd_err) ? 32'd0 : r_mem[w_rd_idx];
                r_rsp_err <= w_rd_err;
            end else if (r_state == c_RESP) begin
                r_rdata   <= 32'd0;
                r_rsp_err <= 1'b0;
            end
        end
    end

    // Storage is never cleared. A store commits at the edge ending RESP,
    // so a reset during RESP suppresses it.
    always_ff @(posedge clk) begin
        if (!reset && (r_state == c_RESP) && r_wr && !r_err) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[r_addr[ADDR_W-1:2]][8*k +: 8] <= w_wlanes[8*k +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
